// File: rtl/fpdiv_pkg.sv
// Shared types for the iterative fixed-point divider: FSM state encoding and counter sizing.
package fpdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach n+d so the final CALC cycle can register the fixed-up result.
  function automatic int cnt_width(input int n, input int d);
    return $clog2(n + d + 1);
  endfunction

endpackage

// File: rtl/fpdiv_datapath.sv
// Operand/remainder/quotient registers with one restoring shift-subtract step per cycle.
// Sign fix-up and divide-by-zero saturation are registered into c/dbz on finish; holds otherwise.
module fpdiv_datapath
  import fpdiv_pkg::*;
#(
  parameter int n    = 32,
  parameter int sign = 1,
  parameter int cw   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          step,
  input  logic          finish,
  input  logic [cw-1:0] cnt,
  input  logic [n-1:0]  a,
  input  logic [n-1:0]  b,
  output logic [n-1:0]  c,
  output logic          dbz
);

  localparam logic [n-1:0] msb     = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] sat_pos = {1'b0, {(n-1){1'b1}}};

  logic [n-1:0] a_r, b_r, q;
  logic [n:0]   rem;
  logic [n-1:0] c_r;
  logic         dbz_r;

  logic         a_neg, b_neg, b_zero, din, trial_neg;
  logic [n-1:0] a_mag, b_mag, bit_mask, res;
  logic [n+1:0] shifted, trial;

  always_comb begin
    a_neg  = (sign != 0) && a_r[n-1];
    b_neg  = (sign != 0) && b_r[n-1];
    // Unsigned n-bit magnitude keeps 2^(n-1) exact for the most-negative operand.
    a_mag  = a_neg ? -a_r : a_r;
    b_mag  = b_neg ? -b_r : b_r;
    b_zero = (b_r == '0);

    // Dividend is a_mag followed by d zero bits, consumed MSB first.
    bit_mask  = msb >> cnt;
    din       = |(a_mag & bit_mask);
    shifted   = {rem, din};
    trial     = shifted - {2'b00, b_mag};
    trial_neg = trial[n+1];

    res = '0;
    if (b_zero) begin
      if (sign != 0) res = a_neg ? msb : sat_pos;
      else           res = '1;
    end else begin
      res = (a_neg ^ b_neg) ? -q : q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_r   <= '0;
      b_r   <= '0;
      rem   <= '0;
      q     <= '0;
      c_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      if (load) begin
        a_r <= a;
        b_r <= b;
        rem <= '0;
        q   <= '0;
      end
      if (step) begin
        rem <= trial_neg ? shifted[n:0] : trial[n:0];
        q   <= {q[n-2:0], ~trial_neg};
      end
      if (finish) begin
        c_r   <= res;
        dbz_r <= b_zero;
      end
    end
  end

  assign c   = c_r;
  assign dbz = dbz_r;

endmodule

// File: rtl/fpdiv_iter.sv
// Iterative fixed-point divider c = (a<<d)/b; result valid n+d+1 cycles after accept.
// Single operation in flight: recv_rdy only in IDLE, result held in DONE until send_rdy.
module fpdiv_iter
  import fpdiv_pkg::*;
#(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter int sign = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] c,
  output logic         dbz
);

  localparam int             cw       = cnt_width(n, d);
  localparam logic [cw-1:0]  cnt_last = cw'(n + d);

  state_t        state, state_nx;
  logic [cw-1:0] cnt;
  logic          load, step, finish;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    recv_rdy = 1'b0;
    send_val = 1'b0;
    load     = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) begin
          load     = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        // n+d step cycles, then one cycle registering the signed/saturated result.
        if (cnt == cnt_last) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        send_val = 1'b1;
        if (send_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)    cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + cw'(1);
  end

  fpdiv_datapath #(
    .n    (n),
    .sign (sign),
    .cw   (cw)
  ) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .finish (finish),
    .cnt    (cnt),
    .a      (a),
    .b      (b),
    .c      (c),
    .dbz    (dbz)
  );

endmodule

// File: tb/tb_fpdiv_iter.sv
// Randomized and directed checks of fpdiv_iter (n=32, d=16, signed) against an arithmetic model.
module tb_fpdiv_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        recv_val = 1'b0;
  logic        send_rdy = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        recv_rdy, send_val, dbz;
  logic [31:0] c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpdiv_iter #(.n(32), .d(16), .sign(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .a        (a_i),
    .b        (b_i),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .c        (c),
    .dbz      (dbz)
  );

  // Model: {dbz, c} from signed fixed-point arithmetic on 64-bit integers.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      r = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {1'b1, r};
    end
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = (ma * 65536) / mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    r = q[31:0];
    return {1'b0, r};
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    recv_val = 1'b1;
    a_i = a;
    b_i = b;
    @(posedge clk); #1;
    recv_val = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!send_val && lat < 200);
  endtask

  task automatic accept();
    send_rdy = 1'b1;
    @(posedge clk); #1;
    send_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL rst_recv_rdy: got %b want 1", recv_rdy); end
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL rst_send_val: got %b want 0", send_val); end
    total++; if (c !== 32'd0)       begin bad++; $display("FAIL rst_c: got %h want 0", c); end
    total++; if (dbz !== 1'b0)      begin bad++; $display("FAIL rst_dbz: got %b want 0", dbz); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] va [5] = '{32'h0003_0000, 32'hFFFE_8000, 32'hFFFF_0000, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] vb [5] = '{32'h0002_0000, 32'h0000_8000, 32'h0003_0000, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] vc [5] = '{32'h0001_8000, 32'hFFFD_0000, 32'hFFFF_AAAB, 32'h7FFF_FFFF, 32'h8000_0000};
    logic        vz [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      wait_result(lat);
      total++; if (lat !== 49)        begin bad++; $display("FAIL dir_latency[%0d]: got %0d want 49", i, lat); end
      total++; if (c !== vc[i])       begin bad++; $display("FAIL dir_c[%0d]: got %h want %h", i, c, vc[i]); end
      total++; if (dbz !== vz[i])     begin bad++; $display("FAIL dir_dbz[%0d]: got %b want %b", i, dbz, vz[i]); end
      total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL dir_rdy_done[%0d]: got %b want 0", i, recv_rdy); end
      accept();
      total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL dir_rdy_idle[%0d]: got %b want 1", i, recv_rdy); end
      total++; if (send_val !== 1'b0) begin bad++; $display("FAIL dir_val_idle[%0d]: got %b want 0", i, send_val); end
    end
  endtask

  task automatic test_stall();
    logic [32:0] exp;
    int lat;
    exp = ref_div(32'h0005_0000, 32'h0002_0000);
    start_op(32'h0005_0000, 32'h0002_0000);
    wait_result(lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      total++; if (send_val !== 1'b1)    begin bad++; $display("FAIL stall_val[%0d]: got %b want 1", k, send_val); end
      total++; if (c !== exp[31:0])      begin bad++; $display("FAIL stall_c[%0d]: got %h want %h", k, c, exp[31:0]); end
      total++; if (dbz !== exp[32])      begin bad++; $display("FAIL stall_dbz[%0d]: got %b want %b", k, dbz, exp[32]); end
      total++; if (recv_rdy !== 1'b0)    begin bad++; $display("FAIL stall_rdy[%0d]: got %b want 0", k, recv_rdy); end
    end
    // New operands offered on the send-handshake edge must not be taken there.
    send_rdy = 1'b1;
    recv_val = 1'b1;
    a_i = 32'h0007_0000;
    b_i = 32'hFFFE_0000;
    @(posedge clk); #1;
    send_rdy = 1'b0;
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL hs_val: got %b want 0", send_val); end
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL hs_rdy: got %b want 1", recv_rdy); end
    @(posedge clk); #1;
    recv_val = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    total++; if (recv_rdy !== 1'b0) begin bad++; $display("FAIL hs_accept: got %b want 0", recv_rdy); end
    exp = ref_div(32'h0007_0000, 32'hFFFE_0000);
    wait_result(lat);
    total++; if (lat !== 49)       begin bad++; $display("FAIL hs_latency: got %0d want 49", lat); end
    total++; if (c !== exp[31:0])  begin bad++; $display("FAIL hs_c: got %h want %h", c, exp[31:0]); end
    accept();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit saw;
    start_op(32'h0005_0000, 32'h0002_0000);
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    total++; if (recv_rdy !== 1'b1) begin bad++; $display("FAIL mid_rdy: got %b want 1", recv_rdy); end
    total++; if (send_val !== 1'b0) begin bad++; $display("FAIL mid_val: got %b want 0", send_val); end
    total++; if (c !== 32'd0)       begin bad++; $display("FAIL mid_c: got %h want 0", c); end
    total++; if (dbz !== 1'b0)      begin bad++; $display("FAIL mid_dbz: got %b want 0", dbz); end
    saw = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (send_val) saw = 1'b1;
    end
    total++; if (saw !== 1'b0) begin bad++; $display("FAIL mid_no_send: got %b want 0", saw); end
    start_op(32'h0001_0000, 32'h0003_0000);
    wait_result(lat);
    total++; if (lat !== 49)          begin bad++; $display("FAIL mid_latency: got %0d want 49", lat); end
    total++; if (c !== 32'h0000_5555) begin bad++; $display("FAIL mid_c_after: got %h want 00005555", c); end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic [32:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = b & 32'h0000_FFFF;
        3: b = 32'h8000_0000;
        default: ;
      endcase
      exp = ref_div(a, b);
      start_op(a, b);
      wait_result(lat);
      total++; if (lat !== 49)      begin bad++; $display("FAIL b2b_latency[%0d]: got %0d want 49", i, lat); end
      total++; if (c !== exp[31:0]) begin bad++; $display("FAIL b2b_c[%0d]: a=%h b=%h got %h want %h", i, a, b, c, exp[31:0]); end
      total++; if (dbz !== exp[32]) begin bad++; $display("FAIL b2b_dbz[%0d]: got %b want %b", i, dbz, exp[32]); end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      accept();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
